// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipeline_ctrl_pkg;
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } state_e;

  localparam int         DEFAULT_MEM_TIMEOUT = 255;
  localparam logic [4:0] X0_ADDR             = 5'd0;
endpackage

// File: rtl/pipeline_hazard_controller_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);
  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && !(&count_q)) count_d = count_q + WIDTH'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) count_q <= '0;
    else          count_q <= count_d;
  end

  assign count = count_q;
endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage core: freeze on RAM waits, flush on
// EX redirects, one-cycle bubble on load-use, plus RAM watchdog and counters.
module pipeline_hazard_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [4:0]           id_rs1_address,
  input  logic [4:0]           id_rs2_address,
  input  logic                 id_uses_rs1,
  input  logic                 id_uses_rs2,
  input  logic [4:0]           ex_rd_address,
  input  logic                 ex_reg_wren,
  input  logic                 ex_is_load,
  input  logic                 ex_redirect,
  input  logic                 mem_req,
  input  logic                 mem_ready,
  input  logic                 halt_req,
  output logic                 pc_wren,
  output logic                 if_id_wren,
  output logic                 if_id_flush,
  output logic                 id_ex_wren,
  output logic                 id_ex_bubble,
  output logic                 ex_mem_wren,
  output logic                 halted,
  output logic                 mem_error,
  output logic [CNT_WIDTH-1:0] stall_count,
  output logic [CNT_WIDTH-1:0] flush_count
);
  localparam int            WC_W        = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WC_W-1:0] WC_LAST   = WC_W'(MEM_TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;
  logic            mem_error_q, mem_error_d;

  logic pc_c, if_id_c, id_ex_c, ex_mem_c, flush_c, bubble_c;
  logic freeze, load_use, flush_inc, stall_inc;

  assign freeze = (state_q == ST_RUN && mem_req && !mem_ready) ||
                  (state_q == ST_MEM_WAIT && !mem_ready);

  assign load_use = ex_is_load && ex_reg_wren && (ex_rd_address != X0_ADDR) &&
                    ((id_uses_rs1 && id_rs1_address == ex_rd_address) ||
                     (id_uses_rs2 && id_rs2_address == ex_rd_address));

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    mem_error_d = mem_error_q;
    pc_c        = 1'b1;
    if_id_c     = 1'b1;
    id_ex_c     = 1'b1;
    ex_mem_c    = 1'b1;
    flush_c     = 1'b0;
    bubble_c    = 1'b0;
    flush_inc   = 1'b0;
    if (state_q == ST_HALT) begin
      {pc_c, if_id_c, id_ex_c, ex_mem_c} = 4'b0000;
    end else if (state_q == ST_RUN && halt_req) begin
      {pc_c, if_id_c, id_ex_c, ex_mem_c} = 4'b0000;
      state_d = ST_HALT;
    end else if (freeze) begin
      {pc_c, if_id_c, id_ex_c, ex_mem_c} = 4'b0000;
      if (state_q == ST_RUN) begin
        state_d    = ST_MEM_WAIT;
        wait_cnt_d = '0;
      end else begin
        wait_cnt_d = wait_cnt_q + WC_W'(1);
        if (wait_cnt_q == WC_LAST) begin
          state_d     = ST_HALT;
          mem_error_d = 1'b1;
        end
      end
    end else begin
      // A completing access releases here; halt_req waits for RUN.
      if (state_q == ST_MEM_WAIT) state_d = ST_RUN;
      if (ex_redirect) begin
        flush_c   = 1'b1;
        bubble_c  = 1'b1;
        flush_inc = 1'b1;
      end else if (load_use) begin
        pc_c     = 1'b0;
        if_id_c  = 1'b0;
        bubble_c = 1'b1;
      end
    end
  end

  assign stall_inc = (state_q != ST_HALT) && !pc_c;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      mem_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_error_q <= mem_error_d;
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk(clk), .reset_n(reset_n), .inc(stall_inc), .count(stall_count)
  );
  sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk(clk), .reset_n(reset_n), .inc(flush_inc), .count(flush_count)
  );

  // Reset forces every enable low even before the first clock edge.
  assign pc_wren      = reset_n & pc_c;
  assign if_id_wren   = reset_n & if_id_c;
  assign id_ex_wren   = reset_n & id_ex_c;
  assign ex_mem_wren  = reset_n & ex_mem_c;
  assign if_id_flush  = reset_n & flush_c;
  assign id_ex_bubble = reset_n & bubble_c;
  assign halted       = (state_q == ST_HALT);
  assign mem_error    = mem_error_q;
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed checks of stall/flush sequencing, watchdog, async reset and counters.
module tb_pipeline_hazard_controller;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [4:0]    id_rs1_address, id_rs2_address, ex_rd_address;
  logic          id_uses_rs1, id_uses_rs2, ex_reg_wren, ex_is_load;
  logic          ex_redirect, mem_req, mem_ready, halt_req;
  logic          pc_wren, if_id_wren, if_id_flush, id_ex_wren, id_ex_bubble, ex_mem_wren;
  logic          halted, mem_error;
  logic [CW-1:0] stall_count, flush_count;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [5:0] O_NONE = 6'b000000;
  localparam logic [5:0] O_NORM = 6'b110101;
  localparam logic [5:0] O_LU   = 6'b000111;
  localparam logic [5:0] O_RDR  = 6'b111111;

  logic [5:0] outs;
  assign outs = {pc_wren, if_id_wren, if_id_flush, id_ex_wren, id_ex_bubble, ex_mem_wren};

  always #5 clk = ~clk;

  pipeline_hazard_controller #(.MEM_TIMEOUT(4), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset_n(reset_n),
    .id_rs1_address(id_rs1_address), .id_rs2_address(id_rs2_address),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd_address(ex_rd_address), .ex_reg_wren(ex_reg_wren),
    .ex_is_load(ex_is_load), .ex_redirect(ex_redirect),
    .mem_req(mem_req), .mem_ready(mem_ready), .halt_req(halt_req),
    .pc_wren(pc_wren), .if_id_wren(if_id_wren), .if_id_flush(if_id_flush),
    .id_ex_wren(id_ex_wren), .id_ex_bubble(id_ex_bubble), .ex_mem_wren(ex_mem_wren),
    .halted(halted), .mem_error(mem_error),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    id_rs1_address = '0; id_rs2_address = '0; ex_rd_address = '0;
    id_uses_rs1 = 0; id_uses_rs2 = 0; ex_reg_wren = 0; ex_is_load = 0;
    ex_redirect = 0; mem_req = 0; mem_ready = 0; halt_req = 0;

    #3;
    chk("rst_outs", 32'(outs), 32'(O_NONE));
    chk("rst_halted", 32'(halted), 0);
    chk("rst_mem_error", 32'(mem_error), 0);
    chk("rst_stall", 32'(stall_count), 0);
    chk("rst_flush", 32'(flush_count), 0);
    #9 reset_n = 1'b1;
    #1 chk("normal", 32'(outs), 32'(O_NORM));

    // load-use on rs1
    ex_is_load = 1; ex_reg_wren = 1; ex_rd_address = 5; id_rs1_address = 5; id_uses_rs1 = 1;
    #1 chk("lu_stall", 32'(outs), 32'(O_LU));
    tick;
    ex_is_load = 0;
    #1 chk("lu_clear", 32'(outs), 32'(O_NORM));
    chk("lu_stall_cnt", 32'(stall_count), 1);

    // rd = x0 never hazards
    ex_is_load = 1; ex_rd_address = 0; id_rs1_address = 0;
    #1 chk("lu_x0", 32'(outs), 32'(O_NORM));
    tick;
    chk("lu_x0_cnt", 32'(stall_count), 1);

    // match without use, then rs2 hazard, then no reg_wren
    ex_rd_address = 7; id_rs1_address = 7; id_uses_rs1 = 0;
    #1 chk("lu_nouse", 32'(outs), 32'(O_NORM));
    id_rs2_address = 7; id_uses_rs2 = 1;
    #1 chk("lu_rs2", 32'(outs), 32'(O_LU));
    tick;
    chk("lu_rs2_cnt", 32'(stall_count), 2);
    ex_reg_wren = 0;
    #1 chk("lu_nowren", 32'(outs), 32'(O_NORM));
    tick;

    // redirect beats load-use
    ex_reg_wren = 1; ex_redirect = 1;
    #1 chk("redir_lu", 32'(outs), 32'(O_RDR));
    tick;
    chk("redir_flush_cnt", 32'(flush_count), 1);
    chk("redir_stall_cnt", 32'(stall_count), 2);
    ex_is_load = 0;

    // 3 wait cycles, redirect held through the freeze
    mem_req = 1; mem_ready = 0;
    #1 chk("freeze_run", 32'(outs), 32'(O_NONE));
    tick;
    chk("freeze_mw1", 32'(outs), 32'(O_NONE));
    tick;
    chk("freeze_mw2", 32'(outs), 32'(O_NONE));
    tick;
    chk("freeze_stall_cnt", 32'(stall_count), 5);
    chk("freeze_flush_cnt", 32'(flush_count), 1);
    mem_ready = 1;
    #1 chk("release_redir", 32'(outs), 32'(O_RDR));
    tick;
    mem_req = 0; mem_ready = 0; ex_redirect = 0;
    #1 chk("back_run", 32'(outs), 32'(O_NORM));
    chk("release_flush_cnt", 32'(flush_count), 2);
    chk("release_stall_cnt", 32'(stall_count), 5);

    // watchdog: 1 RUN-freeze + 4 MEM_WAIT cycles
    mem_req = 1;
    repeat (4) tick;
    chk("wd_pre_halted", 32'(halted), 0);
    chk("wd_pre_outs", 32'(outs), 32'(O_NONE));
    tick;
    chk("wd_halted", 32'(halted), 1);
    chk("wd_mem_error", 32'(mem_error), 1);
    chk("wd_stall_cnt", 32'(stall_count), 10);
    mem_ready = 1;
    #1 chk("halt_hold", 32'(outs), 32'(O_NONE));
    tick; tick;
    chk("halt_nostall", 32'(stall_count), 10);
    chk("halt_sticky", 32'(halted), 1);

    // async reset mid-MEM_WAIT
    reset_n = 0; #1 reset_n = 1;
    mem_req = 1; mem_ready = 0;
    tick; tick;
    #2 reset_n = 0;
    #1 chk("rst_async_outs", 32'(outs), 32'(O_NONE));
    chk("rst_async_stall", 32'(stall_count), 0);
    chk("rst_async_err", 32'(mem_error), 0);
    chk("rst_async_halted", 32'(halted), 0);
    #1 reset_n = 1;
    mem_req = 0;
    #1 chk("rst_run", 32'(outs), 32'(O_NORM));

    // halt request in RUN
    halt_req = 1;
    #1 chk("halt_req_outs", 32'(outs), 32'(O_NONE));
    tick;
    chk("halt_req_halted", 32'(halted), 1);
    chk("halt_req_err", 32'(mem_error), 0);
    chk("halt_req_stall", 32'(stall_count), 1);
    halt_req = 0;

    // saturation
    #1 reset_n = 0; #1 reset_n = 1;
    ex_is_load = 1; ex_reg_wren = 1; ex_rd_address = 9; id_rs1_address = 9; id_uses_rs1 = 1;
    repeat (14) tick;
    chk("sat_14", 32'(stall_count), 14);
    repeat (6) tick;
    chk("sat_hold", 32'(stall_count), 15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_controller.md
# pipeline_hazard_controller

Central stall/flush sequencer for the 5-stage core. It drives the `wren` enables of the PC and of the IF/ID, ID/EX and EX/MEM pipeline registers, plus the squash controls. Every cycle it resolves load-use hazards, EX-stage redirects and multi-cycle RAM waits in one fixed priority order. It also provides a RAM watchdog and saturating stall/flush counters for debug.

## Interface
- MEM_TIMEOUT, 255: maximum consecutive MEM_WAIT cycles before a fatal halt (1..65535).
- CNT_WIDTH, 32: width of the performance counters.

- clk  in  1  single clock; all state updates on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- id_rs1_address  in  5  rs1 of the instruction in ID
- id_rs2_address  in  5  rs2 of the instruction in ID
- id_uses_rs1  in  1  ID instruction reads rs1
- id_uses_rs2  in  1  ID instruction reads rs2
- ex_rd_address  in  5  rd of the instruction in EX (ID/EX `rd_address`)
- ex_reg_wren  in  1  ID/EX `reg_wren`
- ex_is_load  in  1  EX instruction writes back RAM data (ID/EX `reg_write_data_src`==1)
- ex_redirect  in  1  EX resolved a taken branch or jump this cycle
- mem_req  in  1  MEM stage accesses RAM this cycle
- mem_ready  in  1  RAM completes the access this cycle
- halt_req  in  1  ECALL/EBREAK or external halt
- pc_wren  out  1  PC update enable
- if_id_wren  out  1  IF/ID enable
- if_id_flush  out  1  load NOP into IF/ID
- id_ex_wren  out  1  ID/EX `wren`
- id_ex_bubble  out  1  top level forces `in_reg_wren`, `in_ram_wren` and `in_next_pc_src` to 0
- ex_mem_wren  out  1  EX/MEM enable
- halted  out  1  core stopped in HALT
- mem_error  out  1  sticky watchdog expiry
- stall_count  out  CNT_WIDTH  cycles with pc_wren=0, excluding HALT
- flush_count  out  CNT_WIDTH  applied redirects

## Operation
- FSM states: RUN, MEM_WAIT, HALT.
- Priority of decisions (highest first): reset, HALT, freeze, redirect, load-use, normal.
- Freeze: in RUN with mem_req&&!mem_ready, or in MEM_WAIT with !mem_ready.
  - All four wren outputs are 0. Flush and bubble are 0.
- Redirect: ex_redirect with no freeze.
  - All wren are 1, if_id_flush=1, id_ex_bubble=1.
  - flush_count increments by 1.
- Load-use: applies when all of the following hold, with no freeze and no redirect:
  - ex_is_load && ex_reg_wren && ex_rd_address!=0;
  - (id_uses_rs1 && rs1==ex_rd_address) || (id_uses_rs2 && rs2==ex_rd_address).
  - Outputs: pc_wren=0, if_id_wren=0, id_ex_wren=1, id_ex_bubble=1, ex_mem_wren=1.
- Normal: all wren are 1; flush and bubble are 0.
- Transitions:
  - RUN to MEM_WAIT on mem_req&&!mem_ready.
  - RUN to HALT on halt_req, which wins over everything. In that cycle all wren are 0.
  - MEM_WAIT to RUN on mem_ready. That cycle is not frozen; redirect and load-use rules apply normally.
  - MEM_WAIT to HALT when wait_cnt==MEM_TIMEOUT-1 and !mem_ready. mem_error is set on that edge.
  - halt_req is ignored in MEM_WAIT until the access completes.
  - HALT is left only by reset.
- wait_cnt:
  - Cleared on entry to MEM_WAIT.
  - Increments each MEM_WAIT cycle.
  - Width is clog2(MEM_TIMEOUT+1).
- Counters saturate at all-ones and never wrap.
  - stall_count increments in every non-HALT cycle with pc_wren=0, including freeze and load-use cycles.

## Timing
- All wren, flush and bubble outputs are combinational from state and inputs, so a stall takes effect in the same cycle.
- state, wait_cnt, the counters and mem_error are registered. halted is decoded from state.
- While reset_n=0, asynchronously:
  - state=RUN, wait_cnt=0, counters=0, mem_error=0, halted=0;
  - pc_wren, if_id_wren, id_ex_wren and ex_mem_wren are forced to 0, as are flush and bubble.
- Reset released mid-access: restart in RUN. The RAM request is re-evaluated from the inputs.
- Load-use costs exactly 1 stall cycle. The next cycle the load has moved to MEM, so the hazard is clear.
- A RAM access with N wait cycles (N≥1) stalls for N cycles and releases in cycle N+1.
- Redirect during freeze: upstream holds ex_redirect, so the redirect is applied in the release cycle.
- Redirect together with load-use: redirect wins; there is no stall and no stall_count increment.

## Structure
- Shared package `pipeline_ctrl_pkg`:
  - state enum (RUN, MEM_WAIT, HALT);
  - default MEM_TIMEOUT;
  - x0 register address constant.
- One sub-module: `sat_counter` (parameter WIDTH; ports clk, reset_n, inc, count), instantiated twice.

## Test plan
- Load-use: ex_is_load=1, ex_reg_wren=1, ex_rd=5; ID rs1=5 with uses_rs1 -> one cycle of pc_wren=0, if_id_wren=0, id_ex_bubble=1; stall_count=1. Repeat with ex_rd=0 -> no stall.
- RAM wait: mem_req=1, mem_ready low 3 cycles then high -> 3 frozen cycles, MEM_WAIT then RUN, stall_count=3.
- Redirect together with load-use hazard -> if_id_flush=1, id_ex_bubble=1, pc_wren=1; flush_count=1, stall_count unchanged.
- Watchdog: MEM_TIMEOUT=4, mem_ready never asserted -> HALT after 1 RUN-freeze cycle + 4 MEM_WAIT cycles; mem_error=1, halted=1, all wren 0 until reset.
- Async reset asserted mid-MEM_WAIT, off-edge -> all outputs 0 immediately; RUN after release.
- Counter saturation: CNT_WIDTH=4, 20 stall cycles -> stall_count holds 15.
